rgb_entry_ctrl: RTL and testbench

RGB_ENTRY_CTRL -- requirements
Module: rgb_entry_ctrl

---
 rtl/rgb_entry_ctrl.sv | 243 ++++++++++++++++++++++++
 tb/tb_rgb_entry_ctrl.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rgb_entry_ctrl.sv
// rgb_entry_ctrl: keypad entry controller for an RGB colour.
// The user types up to three decimal digits per channel and confirms each with
// enter. A confirmed value of 0..255 is committed to the active channel, which
// then advances R -> G -> B -> DONE. A larger value pulses err and keeps the
// same channel active.
//
// Optional feature macro: RGB_TIMEOUT_EN. When it is defined, a partial entry
// that sits idle for TIMEOUT_CYCLES cycles is discarded.
//
// Ports:
//   clk                    system clock, rising edge
//   reset                  asynchronous, active-high reset
//   key_code[4:0]          0-9 digit, 5'h0C clear, 5'h0F enter, other codes ignored
//   key_stb                single-cycle strobe qualifying key_code
//   disp_c/d/u[4:0]        entry buffer (hundreds/tens/units), 5'd16 = blank
//   chan[1:0]              active channel: 0 R, 1 G, 2 B, 3 done
//   r_val/g_val/b_val[7:0] committed channel values
//   color_valid            high while all three channels are committed
//   busy                   high while a conversion is in progress
//   err                    one-cycle pulse when an entry exceeds 255
//   timeout_clr            one-cycle pulse when the idle timeout discards an entry
module rgb_entry_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 50_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] key_code,
    input  logic       key_stb,
    output logic [4:0] disp_c,
    output logic [4:0] disp_d,
    output logic [4:0] disp_u,
    output logic [1:0] chan,
    output logic [7:0] r_val,
    output logic [7:0] g_val,
    output logic [7:0] b_val,
    output logic       color_valid,
    output logic       busy,
    output logic       err,
    output logic       timeout_clr
);

    localparam logic [4:0] BLANK   = 5'd16;
    localparam logic [4:0] KEY_CLR = 5'h0C;
    localparam logic [4:0] KEY_ENT = 5'h0F;
    localparam logic [9:0] MAX_VAL = 10'd255;

    // A timeout below two cycles leaves no room for an idle cycle.
    if (TIMEOUT_CYCLES < 2) begin : g_timeout_check
        $error("rgb_entry_ctrl: TIMEOUT_CYCLES must be at least 2");
    end

    typedef enum logic [2:0] {
        ENT_R = 3'd0,
        ENT_G = 3'd1,
        ENT_B = 3'd2,
        CONV  = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t     state, state_nxt;
    logic [1:0] cnt, cnt_nxt;
    logic [4:0] disp_c_nxt, disp_d_nxt, disp_u_nxt;
    logic [1:0] chan_nxt;
    logic [7:0] r_nxt, g_nxt, b_nxt;
    logic       err_nxt;
    logic       is_digit, is_clear, is_enter, in_entry;
    logic [9:0] value;

    // Blank digit positions contribute zero to the value.
    function automatic logic [9:0] dig_val(input logic [4:0] d);
        return (d == BLANK) ? 10'd0 : 10'(d);
    endfunction

    function automatic state_t entry_state(input logic [1:0] ch);
        case (ch)
            2'd0:    return ENT_R;
            2'd1:    return ENT_G;
            default: return ENT_B;
        endcase
    endfunction

    function automatic state_t advance_state(input logic [1:0] ch);
        case (ch)
            2'd0:    return ENT_G;
            2'd1:    return ENT_B;
            default: return DONE;
        endcase
    endfunction

    // Key decode: undefined codes behave as if no key was pressed.
    assign is_digit = key_stb && (key_code <= 5'd9);
    assign is_clear = key_stb && (key_code == KEY_CLR);
    assign is_enter = key_stb && (key_code == KEY_ENT);
    assign in_entry = (state == ENT_R) || (state == ENT_G) || (state == ENT_B);

    assign value = dig_val(disp_c) * 10'd100 + dig_val(disp_d) * 10'd10 + dig_val(disp_u);

`ifdef RGB_TIMEOUT_EN
    localparam int unsigned TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [TMO_W-1:0] tmo_cnt, tmo_cnt_nxt;
    logic             tmo_fire;

    // Idle counter: runs only while a partial entry is waiting; any key restarts it.
    always_comb begin
        tmo_cnt_nxt = '0;
        tmo_fire    = 1'b0;
        if (in_entry && (cnt != 2'd0) && !(is_digit || is_clear || is_enter)) begin
            if (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                tmo_fire = 1'b1;
            end else begin
                tmo_cnt_nxt = tmo_cnt + TMO_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmo_cnt     <= '0;
            timeout_clr <= 1'b0;
        end else begin
            tmo_cnt     <= tmo_cnt_nxt;
            timeout_clr <= tmo_fire;
        end
    end
`else
    assign timeout_clr = 1'b0;
`endif

    // Next-state and next-output logic.
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        disp_c_nxt = disp_c;
        disp_d_nxt = disp_d;
        disp_u_nxt = disp_u;
        r_nxt      = r_val;
        g_nxt      = g_val;
        b_nxt      = b_val;
        err_nxt    = 1'b0;
        chan_nxt   = chan;

        case (state)
            ENT_R, ENT_G, ENT_B: begin
                if (is_digit) begin
                    if (cnt < 2'd3) begin
                        disp_c_nxt = disp_d;
                        disp_d_nxt = disp_u;
                        disp_u_nxt = key_code;
                        cnt_nxt    = cnt + 2'd1;
                    end
                end else if (is_clear) begin
                    disp_c_nxt = BLANK;
                    disp_d_nxt = BLANK;
                    disp_u_nxt = BLANK;
                    cnt_nxt    = 2'd0;
                end else if (is_enter && (cnt != 2'd0)) begin
                    state_nxt = CONV;
                end
            end

            // The buffer is held through CONV; chan still names the originating channel.
            CONV: begin
                disp_c_nxt = BLANK;
                disp_d_nxt = BLANK;
                disp_u_nxt = BLANK;
                cnt_nxt    = 2'd0;
                if (value <= MAX_VAL) begin
                    case (chan)
                        2'd0:    r_nxt = value[7:0];
                        2'd1:    g_nxt = value[7:0];
                        default: b_nxt = value[7:0];
                    endcase
                    state_nxt = advance_state(chan);
                end else begin
                    err_nxt   = 1'b1;
                    state_nxt = entry_state(chan);
                end
            end

            DONE: begin
                if (is_digit) begin
                    disp_c_nxt = BLANK;
                    disp_d_nxt = BLANK;
                    disp_u_nxt = key_code;
                    cnt_nxt    = 2'd1;
                    state_nxt  = ENT_R;
                end
            end

            default: state_nxt = ENT_R;
        endcase

`ifdef RGB_TIMEOUT_EN
        if (tmo_fire) begin
            disp_c_nxt = BLANK;
            disp_d_nxt = BLANK;
            disp_u_nxt = BLANK;
            cnt_nxt    = 2'd0;
        end
`endif

        case (state_nxt)
            ENT_R:   chan_nxt = 2'd0;
            ENT_G:   chan_nxt = 2'd1;
            ENT_B:   chan_nxt = 2'd2;
            DONE:    chan_nxt = 2'd3;
            default: chan_nxt = chan;
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ENT_R;
            cnt         <= 2'd0;
            disp_c      <= BLANK;
            disp_d      <= BLANK;
            disp_u      <= BLANK;
            chan        <= 2'd0;
            r_val       <= 8'd0;
            g_val       <= 8'd0;
            b_val       <= 8'd0;
            color_valid <= 1'b0;
            busy        <= 1'b0;
            err         <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            disp_c      <= disp_c_nxt;
            disp_d      <= disp_d_nxt;
            disp_u      <= disp_u_nxt;
            chan        <= chan_nxt;
            r_val       <= r_nxt;
            g_val       <= g_nxt;
            b_val       <= b_nxt;
            color_valid <= (state_nxt == DONE);
            busy        <= (state_nxt == CONV);
            err         <= err_nxt;
        end
    end

endmodule

// File: tb/tb_rgb_entry_ctrl.sv
// Self-checking bench for rgb_entry_ctrl: a decimal-entry model predicts the
// commit/err result of every accepted enter and queues it; a monitor pops and
// compares each result two cycles after its enter strobe.
module tb_rgb_entry_ctrl;

    localparam logic [4:0] BLANK   = 5'd16;
    localparam logic [4:0] K_CLR   = 5'h0C;
    localparam logic [4:0] K_ENT   = 5'h0F;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] key_code;
    logic       key_stb;
    logic [4:0] disp_c, disp_d, disp_u;
    logic [1:0] chan;
    logic [7:0] r_val, g_val, b_val;
    logic       color_valid, busy, err, timeout_clr;

    always #5 clk = ~clk;

    rgb_entry_ctrl #(.TIMEOUT_CYCLES(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .key_code   (key_code),
        .key_stb    (key_stb),
        .disp_c     (disp_c),
        .disp_d     (disp_d),
        .disp_u     (disp_u),
        .chan       (chan),
        .r_val      (r_val),
        .g_val      (g_val),
        .b_val      (b_val),
        .color_valid(color_valid),
        .busy       (busy),
        .err        (err),
        .timeout_clr(timeout_clr)
    );

    typedef struct {
        int due;
        int ch;
        int r;
        int g;
        int b;
        int cv;
        int er;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc      = 0;
    int   busy_end = 0;

    // Reference model of the entry state.
    int         m_ch, m_cnt, m_val, m_r, m_g, m_b;
    logic [4:0] m_c, m_d, m_u;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_ch = 0; m_cnt = 0; m_val = 0;
        m_r = 0; m_g = 0; m_b = 0;
        m_c = BLANK; m_d = BLANK; m_u = BLANK;
        busy_end = 0;
    endtask

    task automatic model_empty();
        m_c = BLANK; m_d = BLANK; m_u = BLANK;
        m_cnt = 0; m_val = 0;
    endtask

    task automatic model_digit(input logic [4:0] code);
        m_c = m_d; m_d = m_u; m_u = code;
        m_val = m_val * 10 + int'(code);
        m_cnt++;
    endtask

    // Drive one key strobe starting at a falling edge; returns at the next falling edge.
    task automatic key(input logic [4:0] code);
        exp_t e;
        bit   accepted_enter;
        accepted_enter = 1'b0;
        key_code = code;
        key_stb  = 1'b1;
        if (cyc >= busy_end) begin
            if (m_ch == 3) begin
                if (code <= 5'd9) begin
                    m_ch = 0;
                    model_empty();
                    model_digit(code);
                end
            end else if (code <= 5'd9) begin
                if (m_cnt < 3) model_digit(code);
            end else if (code == K_CLR) begin
                model_empty();
            end else if (code == K_ENT && m_cnt > 0) begin
                accepted_enter = 1'b1;
                if (m_val <= 255) begin
                    case (m_ch)
                        0:       m_r = m_val;
                        1:       m_g = m_val;
                        default: m_b = m_val;
                    endcase
                    m_ch++;
                    e.er = 0;
                end else begin
                    e.er = 1;
                end
                model_empty();
                e.due = cyc + 2;
                e.ch = m_ch; e.r = m_r; e.g = m_g; e.b = m_b;
                e.cv = (m_ch == 3) ? 1 : 0;
                sb.push_back(e);
                busy_end = cyc + 2;
            end
        end
        @(negedge clk);
        key_stb  = 1'b0;
        key_code = 5'd0;
        if (accepted_enter) check("busy_in_conv", 32'(busy), 32'd1);
    endtask

    task automatic check_state(input string tag);
        check({tag, ".chan"},   32'(chan),        32'(m_ch));
        check({tag, ".r_val"},  32'(r_val),       32'(m_r));
        check({tag, ".g_val"},  32'(g_val),       32'(m_g));
        check({tag, ".b_val"},  32'(b_val),       32'(m_b));
        check({tag, ".cvalid"}, 32'(color_valid), (m_ch == 3) ? 32'd1 : 32'd0);
        check({tag, ".disp_c"}, 32'(disp_c),      32'(m_c));
        check({tag, ".disp_d"}, 32'(disp_d),      32'(m_d));
        check({tag, ".disp_u"}, 32'(disp_u),      32'(m_u));
        check({tag, ".busy"},   32'(busy),        32'd0);
        check({tag, ".err"},    32'(err),         32'd0);
    endtask

    // Scoreboard monitor: compare each queued result on its due cycle.
    always @(negedge clk) begin
        if (sb.size() > 0 && sb[0].due == cyc) begin
            mon_e = sb.pop_front();
            check("sb.chan",   32'(chan),        32'(mon_e.ch));
            check("sb.r_val",  32'(r_val),       32'(mon_e.r));
            check("sb.g_val",  32'(g_val),       32'(mon_e.g));
            check("sb.b_val",  32'(b_val),       32'(mon_e.b));
            check("sb.cvalid", 32'(color_valid), 32'(mon_e.cv));
            check("sb.err",    32'(err),         32'(mon_e.er));
            check("sb.busy",   32'(busy),        32'd0);
            check("sb.disp",   {17'd0, disp_c, disp_d, disp_u}, {17'd0, BLANK, BLANK, BLANK});
        end
    end

    initial begin
        reset    = 1'b1;
        key_code = 5'd0;
        key_stb  = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_state("reset");
        check("reset.tmo", 32'(timeout_clr), 32'd0);

        // 1,2,8,enter -> r_val=128, chan=1, buffer blank
        key(5'd1); key(5'd2); key(5'd8);
        check_state("digits_128");
        key(K_ENT);
        @(negedge clk);
        check_state("commit_r");

        // 300 in ENT_G -> err pulse, same channel, g_val untouched
        key(5'd3); key(5'd0); key(5'd0); key(K_ENT);
        @(negedge clk);
        @(negedge clk);
        check("err_one_cycle", 32'(err), 32'd0);
        check_state("after_err");

        // G=0, B=7 -> DONE
        key(5'd0); key(K_ENT); @(negedge clk);
        key(5'd7); key(K_ENT); @(negedge clk);
        check_state("done_1");

        // clear and enter ignored in DONE; a digit restarts at R
        key(K_CLR); key(K_ENT);
        check_state("done_ignore");
        key(5'd2);
        check_state("restart_r");

        // 255 / 0 / 7
        key(5'd5); key(5'd5); key(K_ENT); @(negedge clk);
        key(5'd0); key(K_ENT); @(negedge clk);
        key(5'd7); key(K_ENT); @(negedge clk);
        check_state("done_255_0_7");

        // Buffer full: fourth digit ignored; clear; enter on empty ignored; undefined codes ignored
        key(5'd4); key(5'd5); key(5'd6); key(5'd7);
        check_state("full_456");
        key(5'd10); key(5'd13); key(5'h1F);
        check_state("undef_codes");
        key(K_CLR);
        check_state("cleared");
        key(K_ENT);
        check_state("enter_empty");

        // Key during CONV is ignored
        key(5'd9); key(K_ENT); key(5'd1);
        check_state("conv_key_ignored");

        // Reset during CONV discards the conversion
        key(5'd4); key(5'd2);
        key_code = K_ENT;
        key_stb  = 1'b1;
        @(negedge clk);
        key_stb = 1'b0;
        check("rst_conv.busy", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        check("rst_conv.async_chan", 32'(chan), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        @(negedge clk);
        check_state("rst_conv");
        @(negedge clk);
        check("rst_conv.err_late", 32'(err), 32'd0);

`ifdef RGB_TIMEOUT_EN
        // Idle timeout discards the partial entry
        key(5'd3); key(K_ENT); @(negedge clk);
        key(5'd9);
        repeat (7) @(negedge clk);
        check("tmo.not_yet", 32'(timeout_clr), 32'd0);
        check("tmo.buf_held", 32'(disp_u), 32'd9);
        @(negedge clk);
        check("tmo.pulse", 32'(timeout_clr), 32'd1);
        model_empty();
        check_state("tmo_blank");
        @(negedge clk);
        check("tmo.pulse_end", 32'(timeout_clr), 32'd0);
`else
        // Without the timeout a partial entry survives long idle periods
        key(5'd9);
        repeat (12) begin
            @(negedge clk);
            check("no_tmo.clr", 32'(timeout_clr), 32'd0);
        end
        check_state("no_tmo_held");
`endif

        repeat (3) @(negedge clk);
        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
